// File: rtl/prbs7_if.sv
// Serial link-test bundle between a PRBS7 source/receiver front end and the checker.
// The master drives the received bit stream, and the slave reports lock and error status.
interface prbs7_if #(
  parameter int ERR_W = 16
);
  logic             din;
  logic             din_valid;
  logic             clr;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;

  modport master (
    output din, din_valid, clr,
    input  locked, err_pulse, err_count
  );

  modport slave (
    input  din, din_valid, clr,
    output locked, err_pulse, err_count
  );
endinterface

// File: rtl/prbs7_checker.sv
// Self-synchronising checker for the XNOR PRBS7 pattern (x^7 + x^6 + 1).
// It locks after a run of correct predictions, counts errors while locked, and drops lock on an error burst.
module prbs7_checker #(
  parameter int LOCK_MATCHES = 16,
  parameter int UNLOCK_ERRS  = 4,
  parameter int ERR_W        = 16
) (
  input  logic   clk,
  input  logic   rst,
  prbs7_if.slave bus
);

  typedef enum logic [1:0] {FILL, VERIFY, LOCKED} state_t;

  localparam logic [7:0] LOCK_LAST   = 8'(LOCK_MATCHES - 1);
  localparam logic [7:0] UNLOCK_LAST = 8'(UNLOCK_ERRS - 1);

  state_t           state_q, state_d;
  logic [6:0]       sr_q, sr_d;
  logic [2:0]       fill_cnt_q, fill_cnt_d;
  logic [7:0]       match_cnt_q, match_cnt_d;
  logic [7:0]       run_err_q, run_err_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic             exp_bit, illegal, match, count_err;

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    fill_cnt_d  = fill_cnt_q;
    match_cnt_d = match_cnt_q;
    run_err_d   = run_err_q;
    err_pulse_d = 1'b0;
    count_err   = 1'b0;
    exp_bit     = ~(sr_q[6] ^ sr_q[5]);
    // All-ones is the XNOR lock-up state, so landing there is always an error.
    illegal     = ({sr_q[5:0], bus.din} == 7'h7F);
    match       = (bus.din == exp_bit) && !illegal;

    if (bus.din_valid) begin
      sr_d = {sr_q[5:0], bus.din};
      case (state_q)
        FILL: begin
          if (fill_cnt_q == 3'd6) begin
            state_d     = VERIFY;
            match_cnt_d = 8'd0;
          end else begin
            fill_cnt_d = fill_cnt_q + 3'd1;
          end
        end
        VERIFY: begin
          if (!match) begin
            match_cnt_d = 8'd0;
          end else if (match_cnt_q == LOCK_LAST) begin
            state_d   = LOCKED;
            run_err_d = 8'd0;
          end else begin
            match_cnt_d = match_cnt_q + 8'd1;
          end
        end
        LOCKED: begin
          if (match) begin
            run_err_d = 8'd0;
          end else begin
            err_pulse_d = 1'b1;
            count_err   = 1'b1;
            if (run_err_q == UNLOCK_LAST) begin
              state_d    = FILL;
              fill_cnt_d = 3'd0;
            end else begin
              run_err_d = run_err_q + 8'd1;
            end
          end
        end
        default: state_d = FILL;
      endcase
    end

    locked_d = (state_d == LOCKED);

    // A clear that coincides with a counted error leaves that error in the count.
    err_count_d = err_count_q;
    if (bus.clr) begin
      err_count_d = count_err ? ERR_W'(1) : '0;
    end else if (count_err && (err_count_q != '1)) begin
      err_count_d = err_count_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      sr_q        <= 7'd0;
      fill_cnt_q  <= 3'd0;
      match_cnt_q <= 8'd0;
      run_err_q   <= 8'd0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      fill_cnt_q  <= fill_cnt_d;
      match_cnt_q <= match_cnt_d;
      run_err_q   <= run_err_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_prbs7_checker.sv
// Directed bench for prbs7_checker: a default instance plus a 4-bit error-counter instance, both fed the same stream.
module tb_prbs7_checker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prbs7_if #(.ERR_W(16)) ifa ();
  prbs7_if #(.ERR_W(4))  ifb ();

  prbs7_checker #(.LOCK_MATCHES(16), .UNLOCK_ERRS(4), .ERR_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave));
  prbs7_checker #(.LOCK_MATCHES(16), .UNLOCK_ERRS(4), .ERR_W(4)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave));

  int         checks   = 0;
  int         failures = 0;
  int         pa       = 0;
  int         pb       = 0;
  logic [6:0] g;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference XNOR PRBS7 source; seed 7'h00 yields 1 first.
  task automatic gen(output logic b);
    b = ~(g[6] ^ g[5]);
    g = {g[5:0], b};
  endtask

  task automatic drive(input logic d, input logic v, input logic c);
    ifa.din = d; ifa.din_valid = v; ifa.clr = c;
    ifb.din = d; ifb.din_valid = v; ifb.clr = c;
    @(posedge clk);
    #1;
    if (ifa.err_pulse === 1'b1) pa++;
    if (ifb.err_pulse === 1'b1) pb++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    g  = 7'h00;
    pa = 0;
    pb = 0;
  endtask

  // Flip one transmitted 1 to 0 so that no all-ones window can appear; run 30 samples in total.
  task automatic flip_one(input logic use_clr, output int fidx);
    logic b;
    logic done;
    done = 1'b0;
    fidx = -1;
    for (int j = 0; j < 30; j++) begin
      gen(b);
      if (!done && b && j >= 2) begin
        done = 1'b1;
        fidx = j;
        drive(1'b0, 1'b1, use_clr);
      end else begin
        drive(b, 1'b1, 1'b0);
      end
    end
  endtask

  initial begin
    logic         b;
    int           fidx;
    int           vc;
    int           cyc;
    int           seen;
    logic [39:0]  pm;
    logic [39:0]  em;

    ifa.din = 0; ifa.din_valid = 0; ifa.clr = 0;
    ifb.din = 0; ifb.din_valid = 0; ifb.clr = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_locked", int'(ifa.locked), 0);
    check("rst_pulse", int'(ifa.err_pulse), 0);
    check("rst_count", int'(ifa.err_count), 0);
    check("rst_count_b", int'(ifb.err_count), 0);
    rst = 1'b0;
    g = 7'h00;

    // Clean stream: lock lands exactly on sample 23.
    for (int i = 1; i <= 1000; i++) begin
      gen(b);
      drive(b, 1'b1, 1'b0);
      if (i == 22) check("clean_not_locked_22", int'(ifa.locked), 0);
      if (i == 23) check("clean_locked_23", int'(ifa.locked), 1);
    end
    check("clean_locked_end", int'(ifa.locked), 1);
    check("clean_pulses", pa, 0);
    check("clean_count", int'(ifa.err_count), 0);

    // Single flip: errors at the flip and when it feeds back 6 and 7 samples later.
    pm = '0;
    fidx = -1;
    for (int j = 0; j < 40; j++) begin
      gen(b);
      if (fidx < 0 && b && j >= 2) begin
        fidx = j;
        drive(1'b0, 1'b1, 1'b0);
      end else begin
        drive(b, 1'b1, 1'b0);
      end
      pm[j] = ifa.err_pulse;
    end
    em = '0;
    if (fidx >= 0 && fidx <= 32) begin
      em[fidx]   = 1'b1;
      em[fidx+6] = 1'b1;
      em[fidx+7] = 1'b1;
    end
    check("flip_found", int'(fidx >= 0 && fidx <= 32), 1);
    check("flip_pulse_pos_lo", int'(pm[31:0]), int'(em[31:0]));
    check("flip_pulse_pos_hi", int'(pm[39:32]), int'(em[39:32]));
    check("flip_count", int'(ifa.err_count), 3);
    check("flip_locked", int'(ifa.locked), 1);

    // Inverted stream: four consecutive errors drop lock; clean data relocks after 23 samples.
    gen(b);
    drive(b, 1'b1, 1'b1);
    check("clr_count", int'(ifa.err_count), 0);
    for (int j = 0; j < 4; j++) begin
      gen(b);
      drive(~b, 1'b1, 1'b0);
      check("inv_pulse", int'(ifa.err_pulse), 1);
      if (j == 2) check("inv_locked_3", int'(ifa.locked), 1);
    end
    check("inv_unlocked", int'(ifa.locked), 0);
    check("inv_count", int'(ifa.err_count), 4);
    for (int i = 1; i <= 23; i++) begin
      gen(b);
      drive(b, 1'b1, 1'b0);
      if (i == 22) check("relock_22", int'(ifa.locked), 0);
      if (i == 23) check("relock_23", int'(ifa.locked), 1);
    end

    // Stuck-at-1 from reset never locks.
    do_reset();
    seen = 0;
    for (int i = 0; i < 500; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      if (ifa.locked === 1'b1) seen++;
    end
    check("stuck_never_locked", seen, 0);
    check("stuck_count", int'(ifa.err_count), 0);

    // Stuck-at-1 while locked: lock lost within 7 + 4 samples.
    do_reset();
    for (int i = 0; i < 23; i++) begin
      gen(b);
      drive(b, 1'b1, 1'b0);
    end
    check("stuck2_locked", int'(ifa.locked), 1);
    for (int i = 0; i < 11; i++) drive(1'b1, 1'b1, 1'b0);
    check("stuck2_unlocked", int'(ifa.locked), 0);

    // Gapped valid: lock still lands on the 23rd valid sample, and no errors.
    do_reset();
    vc = 0;
    cyc = 0;
    while (vc < 23 && cyc < 400) begin
      cyc++;
      if ($urandom_range(0, 1) == 1) begin
        gen(b);
        vc++;
        drive(b, 1'b1, 1'b0);
        if (vc == 22) check("gap_not_locked_22", int'(ifa.locked), 0);
        if (vc == 23) check("gap_locked_23", int'(ifa.locked), 1);
      end else begin
        drive(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
    end
    check("gap_reached_23", vc, 23);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        gen(b);
        drive(b, 1'b1, 1'b0);
      end else begin
        drive(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
    end
    check("gap_locked_end", int'(ifa.locked), 1);
    check("gap_pulses", pa, 0);
    check("gap_count", int'(ifa.err_count), 0);

    // Saturation: 18 errors into a 4-bit counter hold at 15.
    do_reset();
    for (int i = 0; i < 23; i++) begin
      gen(b);
      drive(b, 1'b1, 1'b0);
    end
    for (int k = 0; k < 6; k++) flip_one(1'b0, fidx);
    check("sat_pulses_b", pb, 18);
    check("sat_count_b", int'(ifb.err_count), 15);
    check("sat_count_a", int'(ifa.err_count), 18);
    check("sat_locked", int'(ifb.locked), 1);

    // Clear coincident with an error leaves a count of 1.
    fidx = -1;
    for (int j = 0; j < 10 && fidx < 0; j++) begin
      gen(b);
      if (b) begin
        fidx = j;
        drive(1'b0, 1'b1, 1'b1);
      end else begin
        drive(b, 1'b1, 1'b0);
      end
    end
    check("clr_err_count_b", int'(ifb.err_count), 1);
    check("clr_err_count_a", int'(ifa.err_count), 1);
    check("clr_err_pulse", int'(ifb.err_pulse), 1);

    // Asynchronous reset mid-lock, sampled before the next clock edge.
    #2;
    rst = 1'b1;
    #1;
    check("async_locked", int'(ifb.locked), 0);
    check("async_pulse", int'(ifb.err_pulse), 0);
    check("async_count_b", int'(ifb.err_count), 0);
    check("async_count_a", int'(ifa.err_count), 0);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prbs7_checker.md
# prbs7_checker

Serial PRBS7 checker, receiver end of the XNOR-LFSR link-test pattern (polynomial x^7 + x^6 + 1, XNOR feedback). It sits behind a deserializer or loopback path and samples one bit per qualified clock. It self-synchronizes to the incoming stream and declares lock after a run of correct predictions. While locked it flags and counts bit errors, and it drops lock on a run of consecutive errors.

## Interface
- `LOCK_MATCHES`, default 16: consecutive correct predictions required to declare lock. Legal range 1..255.
- `UNLOCK_ERRS`, default 4: consecutive mispredictions while locked that force loss of lock. Legal range 1..255.
- `ERR_W`, default 16: width of the saturating error counter.
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `din`, input, 1: received serial bit.
- `din_valid`, input, 1: `din` is sampled only when this is 1; otherwise all state holds.
- `clr`, input, 1: synchronous clear of `err_count`.
- `locked`, output, 1: checker is in LOCKED.
- `err_pulse`, output, 1: one-cycle flag for a mismatch detected while LOCKED.
- `err_count`, output, ERR_W: saturating count of LOCKED mismatches.

## Operation
- The shift register `sr[6:0]` holds the last 7 valid bits, with `sr[6]` the oldest. On every valid sample in every state, `sr <= {sr[5:0], din}`, so the checker self-synchronizes.
- Expected bit: `exp = ~(sr[6] ^ sr[5])`, evaluated on `sr` before the shift. A match is `din == exp`.
- Illegal pattern: if the post-shift `sr` equals 7'h7F (the XNOR lock-up state), the sample is treated as a mismatch even when `din == exp`. A legal stream never contains 7 consecutive ones.
- States: FILL, VERIFY, LOCKED. Reset enters FILL.
- FILL:
  - `fill_cnt` counts valid samples.
  - On the 7th valid sample, go to VERIFY with `match_cnt` = 0.
  - No compare happens in FILL.
- VERIFY:
  - A match increments `match_cnt`.
  - A mismatch clears `match_cnt` to 0 and stays in VERIFY.
  - When `match_cnt` would reach `LOCK_MATCHES`, go to LOCKED with `run_err` = 0.
  - No errors are counted in VERIFY.
- LOCKED:
  - A match clears `run_err`.
  - A mismatch asserts `err_pulse`, increments `err_count` (saturating at all-ones), and increments `run_err`.
  - When `run_err` would reach `UNLOCK_ERRS`, go to FILL with `fill_cnt` = 0. The mismatch that triggers the unlock is still counted and pulsed.
- `clr`:
  - Sets `err_count` to 0 on the next edge.
  - If a counted mismatch occurs in the same cycle, `err_count` becomes 1.
  - `clr` does not affect the state, `sr`, or `locked`.
- `din_valid` = 0: FSM, counters and `sr` hold, `err_pulse` = 0. `clr` still acts.

## Timing
- Reset values:
  - `locked` = 0, `err_pulse` = 0, `err_count` = 0.
  - `sr` = 0; `fill_cnt`, `match_cnt` and `run_err` = 0.
  - State = FILL.
- All outputs are registered with no combinational input-to-output path.
- `err_pulse` is high for exactly the cycle after the offending valid sample.
- `locked`:
  - Rises the cycle after the `LOCK_MATCHES`-th consecutive match is sampled.
  - Falls the cycle after the `UNLOCK_ERRS`-th consecutive error is sampled.
- Minimum lock latency from reset with a clean stream is 7 + `LOCK_MATCHES` valid samples; outputs update one clock after the final sample.
- Reset asserted mid-operation clears everything immediately, independent of `clk`. The checker restarts in FILL on the first edge after deassertion.
- Throughput is one bit per clock with no bubbles required.

## Test plan
- **Clean stream:** drive a reference XNOR PRBS7 generator (seed 7'h00, `din_valid` = 1, defaults) for 1000 bits. Require:
  - `locked` = 1 after exactly 23 samples.
  - `err_count` = 0 and no `err_pulse` thereafter.
- **Single bit flip while locked:** invert one bit. Require:
  - Exactly 3 `err_pulse` cycles, at the flip, 6 samples later, and 7 samples later.
  - `err_count` = 3 and `locked` stays 1.
- **Inverted stream after lock:** switch to `~prbs`. Require:
  - 4 consecutive `err_pulse` cycles, `err_count` = 4.
  - `locked` falls after the 4th.
  - Relock after 7 + 16 further clean samples.
- **Stuck-at-1 input from reset:** require `locked` to stay 0 for 500 samples. Separately, stuck-at-1 injected while locked causes loss of lock within 7 + 4 samples.
- **Gapped valid:** toggle `din_valid` randomly at about 50% on a clean stream. Require:
  - Lock after 23 valid samples.
  - Zero errors.
  - Identical results to the gap-free run.
- **Saturation and clear:** with `ERR_W` = 4, inject 6 isolated flips (18 errors). Require:
  - `err_count` holds at 15.
  - `clr` coincident with an error yields 1.
  - `rst` pulse mid-lock zeroes all outputs asynchronously.
